// File: rtl/midi_msg_parser_if.sv
// Byte-in / message-out bundle for midi_msg_parser: FIFO pop side plus message valid/ack side.
interface midi_msg_parser_if;
    logic [7:0] in_data;
    logic       in_d_rdy;
    logic       rdy2rcv;
    logic       msg_valid;
    logic       msg_ack;
    logic [7:0] msg_status;
    logic [6:0] msg_d1;
    logic [6:0] msg_d2;
    logic [1:0] msg_len;

    modport slave (
        input  in_data, in_d_rdy, msg_ack,
        output rdy2rcv, msg_valid, msg_status, msg_d1, msg_d2, msg_len
    );

    modport master (
        output in_data, in_d_rdy, msg_ack,
        input  rdy2rcv, msg_valid, msg_status, msg_d1, msg_d2, msg_len
    );
endinterface

// File: rtl/midi_msg_parser.sv
// Assembles MIDI bytes into messages (running status, realtime interleave, SysEx skip, channel filter).
// Optional MIDI_VEL0_NOTEOFF_EN: Note-On with velocity 0 is emitted as Note-Off.
module midi_msg_parser #(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input logic             clk,
    input logic             rst_n,
    midi_msg_parser_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_status, w_status_nxt;
    logic [6:0] r_d1, w_d1_nxt;
    logic [7:0] r_rs, w_rs_nxt;
    logic       r_rs_valid, w_rs_valid_nxt;

    logic       r_valid;
    logic [7:0] r_out_status;
    logic [6:0] r_out_d1;
    logic [6:0] r_out_d2;
    logic [1:0] r_out_len;

    logic       w_accept;
    logic [7:0] w_byte;
    logic [7:0] w_cur_status;
    logic       w_emit;
    logic [7:0] w_em_status;
    logic [6:0] w_em_d1;
    logic [6:0] w_em_d2;
    logic [1:0] w_em_len;
    logic       w_pass;
    logic [7:0] w_out_status;

    // Number of data bytes following a (non-realtime) status byte.
    function automatic logic [1:0] data_count(input logic [7:0] s);
        logic [1:0] n;
        case (s[7:4])
            4'hC, 4'hD: n = 2'd1;
            4'hF: begin
                case (s[3:0])
                    4'h1, 4'h3: n = 2'd1;
                    4'h2:       n = 2'd2;
                    default:    n = 2'd0;
                endcase
            end
            default:    n = 2'd2;
        endcase
        return n;
    endfunction

    assign w_accept     = bus.in_d_rdy & ~r_valid;
    assign w_byte       = bus.in_data;
    assign w_cur_status = (r_state == IDLE) ? r_rs : r_status;

    // Next-state and message assembly.
    always_comb begin
        w_state_nxt    = r_state;
        w_status_nxt   = r_status;
        w_d1_nxt       = r_d1;
        w_rs_nxt       = r_rs;
        w_rs_valid_nxt = r_rs_valid;
        w_emit         = 1'b0;
        w_em_status    = w_byte;
        w_em_d1        = 7'd0;
        w_em_d2        = 7'd0;
        w_em_len       = 2'd0;
        if (w_accept) begin
            if (w_byte >= 8'hF8) begin
                w_emit = 1'b1;
            end else if (w_byte[7]) begin
                w_state_nxt = IDLE;
                if (w_byte < 8'hF0) begin
                    w_rs_nxt       = w_byte;
                    w_rs_valid_nxt = 1'b1;
                end else begin
                    w_rs_valid_nxt = 1'b0;
                end
                if (w_byte == 8'hF0) begin
                    w_state_nxt = SYSEX;
                end else if (w_byte == 8'hF6) begin
                    w_emit = 1'b1;
                end else if (data_count(w_byte) != 2'd0) begin
                    w_status_nxt = w_byte;
                    w_state_nxt  = WAIT_D1;
                end
            end else if ((r_state == IDLE && r_rs_valid) || r_state == WAIT_D1) begin
                w_status_nxt = w_cur_status;
                w_d1_nxt     = w_byte[6:0];
                if (data_count(w_cur_status) == 2'd1) begin
                    w_emit      = 1'b1;
                    w_em_status = w_cur_status;
                    w_em_d1     = w_byte[6:0];
                    w_em_len    = 2'd1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_D2;
                end
            end else if (r_state == WAIT_D2) begin
                w_emit      = 1'b1;
                w_em_status = r_status;
                w_em_d1     = r_d1;
                w_em_d2     = w_byte[6:0];
                w_em_len    = 2'd2;
                w_state_nxt = IDLE;
            end
        end
    end

    // Channel filter and optional Note-On/velocity-0 rewrite.
    always_comb begin
        w_out_status = w_em_status;
`ifdef MIDI_VEL0_NOTEOFF_EN
        if (w_em_status[7:4] == 4'h9 && w_em_len == 2'd2 && w_em_d2 == 7'd0)
            w_out_status = {4'h8, w_em_status[3:0]};
`endif
        w_pass = w_emit && (OMNI || w_em_status[7:4] == 4'hF || w_em_status[3:0] == CHANNEL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_status     <= 8'd0;
            r_d1         <= 7'd0;
            r_rs         <= 8'd0;
            r_rs_valid   <= 1'b0;
            r_valid      <= 1'b0;
            r_out_status <= 8'd0;
            r_out_d1     <= 7'd0;
            r_out_d2     <= 7'd0;
            r_out_len    <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_status   <= w_status_nxt;
            r_d1       <= w_d1_nxt;
            r_rs       <= w_rs_nxt;
            r_rs_valid <= w_rs_valid_nxt;
            if (w_pass) begin
                r_valid      <= 1'b1;
                r_out_status <= w_out_status;
                r_out_d1     <= w_em_d1;
                r_out_d2     <= w_em_d2;
                r_out_len    <= w_em_len;
            end else if (r_valid && bus.msg_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.rdy2rcv    = ~r_valid;
    assign bus.msg_valid  = r_valid;
    assign bus.msg_status = r_out_status;
    assign bus.msg_d1     = r_out_d1;
    assign bus.msg_d2     = r_out_d2;
    assign bus.msg_len    = r_out_len;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: directed scenarios plus random byte streams against a queue-based message model.
module tb_midi_msg_parser;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    midi_msg_parser_if bus_a ();
    midi_msg_parser_if bus_b ();

    midi_msg_parser u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: message built as a status plus a queue of data bytes.
    bit         m_sysex;
    bit         m_have;
    logic [7:0] m_status;
    logic [6:0] m_data[$];
    logic [7:0] m_rs;
    bit         m_rs_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int need(input logic [7:0] s);
        if (s inside {[8'hC0:8'hDF], 8'hF1, 8'hF3}) return 1;
        if (s inside {[8'h80:8'hBF], [8'hE0:8'hEF], 8'hF2}) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_sysex    = 0;
        m_have     = 0;
        m_status   = 8'h00;
        m_data.delete();
        m_rs       = 8'h00;
        m_rs_valid = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit omni, input logic [3:0] ch,
                              output bit e, output logic [7:0] es, output logic [6:0] e1,
                              output logic [6:0] e2, output logic [1:0] el);
        e = 0; es = b; e1 = 7'd0; e2 = 7'd0; el = 2'd0;
        if (b >= 8'hF8) begin
            e = 1;
        end else if (b[7]) begin
            m_data.delete();
            m_have  = 0;
            m_sysex = 0;
            m_rs_valid = (b < 8'hF0);
            if (b < 8'hF0) m_rs = b;
            if (b == 8'hF0) m_sysex = 1;
            else if (b == 8'hF6) e = 1;
            else if (need(b) > 0) begin
                m_have   = 1;
                m_status = b;
            end
        end else if (!m_sysex) begin
            if (!m_have && m_rs_valid) begin
                m_have   = 1;
                m_status = m_rs;
            end
            if (m_have) begin
                m_data.push_back(b[6:0]);
                if (m_data.size() == need(m_status)) begin
                    e  = 1;
                    es = m_status;
                    e1 = m_data[0];
                    if (m_data.size() > 1) e2 = m_data[1];
                    el = 2'(m_data.size());
                    m_data.delete();
                    m_have = 0;
`ifdef MIDI_VEL0_NOTEOFF_EN
                    if (es[7:4] == 4'h9 && e2 == 7'd0) es = es - 8'h10;
`endif
                    if (!omni && es[3:0] != ch) e = 0;
                end
            end
        end
    endtask

    task automatic drive(input int which, input logic [7:0] b, input logic v);
        if (which == 0) begin
            bus_a.in_data = b; bus_a.in_d_rdy = v;
        end else begin
            bus_b.in_data = b; bus_b.in_d_rdy = v;
        end
    endtask

    task automatic set_ack(input int which, input logic a);
        if (which == 0) bus_a.msg_ack = a;
        else bus_b.msg_ack = a;
    endtask

    // {rdy2rcv, msg_valid, msg_status, msg_d1, msg_d2, msg_len}
    function automatic logic [25:0] obs(input int which);
        if (which == 0)
            return {bus_a.rdy2rcv, bus_a.msg_valid, bus_a.msg_status, bus_a.msg_d1, bus_a.msg_d2, bus_a.msg_len};
        return {bus_b.rdy2rcv, bus_b.msg_valid, bus_b.msg_status, bus_b.msg_d1, bus_b.msg_d2, bus_b.msg_len};
    endfunction

    task automatic send_byte(input int which, input logic [7:0] b, input int ack_dly);
        bit          e;
        logic [7:0]  es;
        logic [6:0]  e1, e2;
        logic [1:0]  el;
        logic [25:0] o;
        model_byte(b, (which == 0), (which == 0) ? 4'd0 : 4'd2, e, es, e1, e2, el);
        @(negedge clk);
        drive(which, b, 1'b1);
        @(negedge clk);
        drive(which, 8'h00, 1'b0);
        o = obs(which);
        check_eq($sformatf("valid_after_%02h", b), 32'(o[24]), 32'(e));
        if (e) begin
            check_eq("status", 32'(o[23:16]), 32'(es));
            check_eq("d1", 32'(o[15:9]), 32'(e1));
            check_eq("d2", 32'(o[8:2]), 32'(e2));
            check_eq("len", 32'(o[1:0]), 32'(el));
            for (int i = 0; i < ack_dly; i++) begin
                @(negedge clk);
                o = obs(which);
                check_eq("hold_valid", 32'(o[24]), 32'd1);
                check_eq("hold_rdy", 32'(o[25]), 32'd0);
                check_eq("hold_status", 32'(o[23:16]), 32'(es));
            end
            set_ack(which, 1'b1);
            @(negedge clk);
            set_ack(which, 1'b0);
            o = obs(which);
            check_eq("ack_clear", 32'(o[24]), 32'd0);
            check_eq("rdy_after_ack", 32'(o[25]), 32'd1);
        end
    endtask

    task automatic send_seq(input int which, input logic [7:0] seq[$]);
        foreach (seq[i]) send_byte(which, seq[i], 1);
    endtask

    function automatic logic [7:0] rand_byte();
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 5)  return 8'h00;
        if (r < 45) return 8'($urandom_range(0, 127));
        if (r < 75) return 8'($urandom_range(8'h80, 8'hEF));
        if (r < 87) return 8'($urandom_range(8'hF0, 8'hF7));
        return 8'($urandom_range(8'hF8, 8'hFF));
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [25:0] o;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus_a.in_data = 8'h00; bus_a.in_d_rdy = 1'b0; bus_a.msg_ack = 1'b0;
        bus_b.in_data = 8'h00; bus_b.in_d_rdy = 1'b0; bus_b.msg_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        o = obs(0);
        check_eq("reset_outputs", 32'(o), 32'h2000000);
        rst_n = 1'b1;

        send_seq(0, '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h50});
        send_seq(0, '{8'h90, 8'h3C, 8'hF8, 8'h40});
        send_seq(0, '{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h45});
        send_byte(0, 8'hC5, 0);
        send_byte(0, 8'h0A, 5);
        send_seq(0, '{8'h93, 8'h3C, 8'h00});

        // Reset in the middle of a note: stale output word must clear asynchronously.
        send_byte(0, 8'hC5, 0);
        send_byte(0, 8'h0A, 0);
        send_seq(0, '{8'h90, 8'h3C});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 o = obs(0);
        check_eq("async_reset_outputs", 32'(o), 32'h2000000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(0, 8'h40, 0);

        send_seq(1, '{8'h91, 8'h3C, 8'h64, 8'h92, 8'h3C, 8'h64, 8'h3D, 8'h20, 8'hFE});
        pulse_reset();

        for (int i = 0; i < 600; i++) send_byte(0, rand_byte(), int'($urandom_range(0, 3)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
